// File: rtl/stream_capture_sink.sv
// Stream capture sink: buffers up to DEPTH signed samples from a valid/ready
// stream and keeps running count, exact sum and peak magnitude for readout.
module stream_capture_sink #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 64
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        s_axis_valid,
    output logic                                        s_axis_ready,
    input  logic signed [DATA_WIDTH-1:0]                s_axis_data,
    input  logic                                        start,
    input  logic [$clog2(DEPTH):0]                      capture_len,
    input  logic [$clog2(DEPTH)-1:0]                    rd_addr,
    output logic signed [DATA_WIDTH-1:0]                rd_data,
    output logic                                        busy,
    output logic                                        done,
    output logic [$clog2(DEPTH):0]                      count,
    output logic signed [DATA_WIDTH+$clog2(DEPTH)-1:0]  sum,
    output logic [DATA_WIDTH-1:0]                       peak_abs
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = DATA_WIDTH + AW;
    localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0]            len_q;
    logic [CW-1:0]            len_clamp;
    logic                     start_ok;
    logic                     xfer;
    logic                     last_xfer;
    logic [DATA_WIDTH-1:0]    data_u;
    logic [DATA_WIDTH-1:0]    sample_abs;
    logic signed [SW-1:0]     sample_ext;
    logic                     rd_hit;

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    assign len_clamp = (capture_len > DEPTH_CW) ? DEPTH_CW : capture_len;
    assign start_ok  = start && (state_q != CAPTURE);
    assign xfer      = s_axis_valid && s_axis_ready;
    assign last_xfer = xfer && (count == (len_q - 1'b1));

    // Unsigned negate so the most negative sample maps to 2^(W-1).
    assign data_u     = s_axis_data;
    assign sample_abs = data_u[DATA_WIDTH-1] ? (~data_u + 1'b1) : data_u;
    assign sample_ext = {{AW{s_axis_data[DATA_WIDTH-1]}}, s_axis_data};
    assign rd_hit     = ({1'b0, rd_addr} < count);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (len_clamp == '0) ? DONE : CAPTURE;
                end
            end
            CAPTURE: begin
                if (last_xfer) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == CAPTURE);
        done         = (state_q == DONE);
        s_axis_ready = (state_q == CAPTURE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            sum      <= '0;
            peak_abs <= '0;
            len_q    <= '0;
            rd_data  <= '0;
        end else begin
            if (start_ok) begin
                count    <= '0;
                sum      <= '0;
                peak_abs <= '0;
                len_q    <= len_clamp;
            end else if (xfer) begin
                count <= count + 1'b1;
                sum   <= sum + sample_ext;
                if (sample_abs > peak_abs) begin
                    peak_abs <= sample_abs;
                end
            end
            rd_data <= rd_hit ? mem[rd_addr] : '0;
        end
    end

    // Buffer is never cleared; readout masks entries at or beyond count.
    always_ff @(posedge clk) begin
        if (rst_n && xfer) begin
            mem[count[AW-1:0]] <= s_axis_data;
        end
    end

endmodule

// File: tb/tb_stream_capture_sink.sv
// Directed bench for stream_capture_sink: capture, clamp, zero length,
// ignored restart and mid-capture reset.
module tb_stream_capture_sink;

    logic               clk;
    logic               rst_n;
    logic               s_axis_valid;
    logic               s_axis_ready;
    logic signed [15:0] s_axis_data;
    logic               start;
    logic [6:0]         capture_len;
    logic [5:0]         rd_addr;
    logic signed [15:0] rd_data;
    logic               busy;
    logic               done;
    logic [6:0]         count;
    logic signed [21:0] sum;
    logic [15:0]        peak_abs;

    int total = 0;
    int bad   = 0;
    logic seen_ready;

    stream_capture_sink #(
        .DATA_WIDTH(16),
        .DEPTH(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_axis_valid(s_axis_valid),
        .s_axis_ready(s_axis_ready),
        .s_axis_data(s_axis_data),
        .start(start),
        .capture_len(capture_len),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .busy(busy),
        .done(done),
        .count(count),
        .sum(sum),
        .peak_abs(peak_abs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic signed [15:0] d);
        s_axis_valid = 1'b1;
        s_axis_data  = d;
        step();
        s_axis_valid = 1'b0;
    endtask

    task automatic arm(input logic [6:0] len);
        capture_len = len;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        s_axis_valid = 1'b0;
        s_axis_data  = '0;
        start        = 1'b0;
        capture_len  = '0;
        rd_addr      = '0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", s_axis_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_sum", sum, 0);
        chk("rst_peak", peak_abs, 0);
        chk("rst_rd", rd_data, 0);
        rst_n = 1'b1;
        step();

        // Four samples, valid held high
        arm(7'd4);
        chk("t1_busy", busy, 1);
        chk("t1_ready", s_axis_ready, 1);
        s_axis_valid = 1'b1;
        s_axis_data = 16'sd100;  step();
        s_axis_data = -16'sd200; step();
        s_axis_data = 16'sd300;  step();
        s_axis_data = 16'sh8000; step();
        chk("t1_ready_after", s_axis_ready, 0);
        chk("t1_done", done, 1);
        step();
        s_axis_valid = 1'b0;
        chk("t1_count", count, 4);
        chk("t1_sum", sum, -32568);
        chk("t1_peak", peak_abs, 32768);
        rd_addr = 6'd3;
        step();
        chk("t1_rd3", rd_data, -32768);

        // Valid toggling every cycle
        arm(7'd3);
        for (int i = 1; i <= 3; i++) begin
            s_axis_valid = 1'b0;
            step();
            send(16'(i));
        end
        chk("t2_ready_after", s_axis_ready, 0);
        for (int i = 0; i < 4; i++) begin
            s_axis_valid = (i % 2 == 1);
            s_axis_data  = 16'sd99;
            step();
        end
        s_axis_valid = 1'b0;
        chk("t2_count", count, 3);
        chk("t2_sum", sum, 6);
        chk("t2_done", done, 1);
        rd_addr = 6'd2;
        step();
        chk("t2_rd2", rd_data, 3);
        rd_addr = 6'd3;
        step();
        chk("t2_rd3_masked", rd_data, 0);

        // Length clamped to DEPTH
        arm(7'd100);
        s_axis_valid = 1'b1;
        s_axis_data  = 16'sd32767;
        for (int i = 0; i < 64; i++) step();
        chk("t3_ready_after", s_axis_ready, 0);
        step();
        s_axis_valid = 1'b0;
        chk("t3_count", count, 64);
        chk("t3_sum", sum, 2097088);
        chk("t3_peak", peak_abs, 32767);
        chk("t3_done", done, 1);
        rd_addr = 6'd63;
        step();
        chk("t3_rd63", rd_data, 32767);

        // Zero length goes straight to DONE
        arm(7'd0);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_count", count, 0);
        chk("t4_sum", sum, 0);
        chk("t4_peak", peak_abs, 0);
        seen_ready = s_axis_ready;
        s_axis_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            seen_ready = seen_ready | s_axis_ready;
        end
        s_axis_valid = 1'b0;
        chk("t4_never_ready", seen_ready, 0);
        chk("t4_count_hold", count, 0);

        // Restart during capture is ignored
        arm(7'd5);
        send(16'sd10);
        send(16'sd20);
        arm(7'd1);
        chk("t5_busy", busy, 1);
        chk("t5_count_mid", count, 2);
        send(16'sd30);
        send(16'sd40);
        send(16'sd50);
        chk("t5_count", count, 5);
        chk("t5_sum", sum, 150);
        chk("t5_peak", peak_abs, 50);
        chk("t5_done", done, 1);

        // Reset mid-capture, with sample and start in the reset cycle
        arm(7'd5);
        send(16'sd7);
        send(16'sd8);
        rst_n        = 1'b0;
        start        = 1'b1;
        capture_len  = 7'd3;
        s_axis_valid = 1'b1;
        s_axis_data  = 16'sd9;
        step();
        start        = 1'b0;
        s_axis_valid = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_ready", s_axis_ready, 0);
        chk("t6_count", count, 0);
        chk("t6_sum", sum, 0);
        chk("t6_peak", peak_abs, 0);
        chk("t6_rd", rd_data, 0);
        rst_n = 1'b1;
        step();
        chk("t6_idle", busy, 0);
        arm(7'd2);
        send(-16'sd5);
        send(16'sd6);
        chk("t6_count2", count, 2);
        chk("t6_sum2", sum, 1);
        chk("t6_peak2", peak_abs, 6);
        chk("t6_done2", done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_capture_sink.md
STREAM_CAPTURE_SINK -- requirements
Module: stream_capture_sink

Interface
REQ-001 Parameter DATA_WIDTH, default 16: signed sample width; matches the algorithm output stream.
REQ-002 Parameter DEPTH, default 64: capture buffer entries; power of two.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1: reset, synchronous, active-low.
REQ-005 Port s_axis_valid  input  1: upstream sample valid; connects to the algorithm output valid.
REQ-006 Port s_axis_ready  output  1: sink ready; driven only from registered state.
REQ-007 Port s_axis_data  input  DATA_WIDTH signed: upstream sample.
REQ-008 Port start  input  1: one-cycle pulse that arms a capture.
REQ-009 Port capture_len  input  $clog2(DEPTH)+1: samples to capture; sampled on an accepted start.
REQ-010 Port rd_addr  input  $clog2(DEPTH): readout address.
REQ-011 Port rd_data  output  DATA_WIDTH signed: registered readout data.
REQ-012 Port busy  output  1: high in CAPTURE.
REQ-013 Port done  output  1: high in DONE (level).
REQ-014 Port count  output  $clog2(DEPTH)+1: samples captured so far.
REQ-015 Port sum  output  DATA_WIDTH+$clog2(DEPTH) signed: exact sum of captured samples.
REQ-016 Port peak_abs  output  DATA_WIDTH unsigned: maximum |sample| captured.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, CAPTURE, DONE.
REQ-018 A transfer SHALL occur only on a cycle where s_axis_valid and s_axis_ready are both 1.
REQ-019 s_axis_ready SHALL be 1 only in CAPTURE; it SHALL be 0 in IDLE and DONE.
REQ-020 start in IDLE or DONE SHALL clear count, sum and peak_abs, latch len_q = min(capture_len, DEPTH), and enter CAPTURE, or enter DONE directly when len_q is 0.
REQ-021 start during CAPTURE SHALL be ignored, with no effect on any state.
REQ-022 Each transfer SHALL write s_axis_data to mem[count], increment count, add the sign-extended sample to sum, and update peak_abs, all in the same edge.
REQ-023 The transfer with count == len_q-1 SHALL move the FSM to DONE, so s_axis_ready is 0 on the next cycle; no further sample is accepted.
REQ-024 |sample| SHALL be computed without overflow: -2^(DATA_WIDTH-1) yields 2^(DATA_WIDTH-1) in unsigned form.
REQ-025 sum SHALL never overflow, because its width covers DEPTH full-scale samples.
REQ-026 s_axis_valid while not ready SHALL be ignored, with no data loss accounting in this block.
REQ-027 rd_data SHALL have 1-cycle latency: rd_data <= (rd_addr < count) ? mem[rd_addr] : 0, in every state, including during capture.
REQ-028 Buffer memory SHALL be write-only from the stream side; it SHALL NOT be reset, and stale entries SHALL be masked by REQ-027.
REQ-029 DONE SHALL hold count, sum and peak_abs stable until the next start or reset.
REQ-030 s_axis_valid gaps during CAPTURE SHALL stall capture indefinitely with no timeout.

Reset
REQ-031 When rst_n is 0 at a rising edge, the block SHALL set the state to IDLE and count, sum, peak_abs and rd_data to 0, so busy, done and s_axis_ready read 0.
REQ-032 Reset mid-CAPTURE SHALL discard the capture; a sample presented in the reset cycle SHALL NOT be counted.
REQ-033 A start pulse coincident with active reset SHALL be ignored.

Verification
REQ-034 The bench SHALL cover: reset, start with capture_len=4, stream 100,-200,300,-32768 with valid always 1 -> count=4, sum=-32568, peak_abs=32768, done=1, s_axis_ready=0 on the cycle after the 4th transfer.
REQ-035 The bench SHALL cover: capture_len=3 with valid toggling every cycle and samples 1,2,3 -> exactly 3 transfers, sum=6; rd_addr=2 gives rd_data=3 one cycle later; rd_addr=3 gives 0.
REQ-036 The bench SHALL cover: capture_len=100 with 64 samples of 32767 -> clamped to DEPTH, count=64, sum=2097088, done=1.
REQ-037 The bench SHALL cover: capture_len=0 -> DONE on the next cycle, count=0, s_axis_ready never 1.
REQ-038 The bench SHALL cover: start pulsed again during CAPTURE after 2 of 5 samples -> ignored; the capture completes with count=5.
REQ-039 The bench SHALL cover: rst_n=0 after 2 of 5 samples -> IDLE, all outputs 0; a new start with capture_len=2 captures afresh with count=2.
